// File: rtl/btn_evt_pkg.sv
// rtl/btn_evt_pkg.sv - event codes, hold FSM states and helpers shared by the button event controller
package btn_evt_pkg;

  localparam int TYPE_W = 2;
  localparam int IDX_W  = 3;
  localparam int CODE_W = TYPE_W + IDX_W;

  typedef enum logic [TYPE_W-1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_LONG    = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_REPEAT,
    ST_WAIT_REL
  } hold_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [7:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_event_ctrl_if.sv
// rtl/btn_event_ctrl_if.sv - event stream handshake between the controller and its consumer
interface btn_event_ctrl_if;

  logic                          evt_valid;
  logic                          evt_ready;
  logic [btn_evt_pkg::CODE_W-1:0] evt_code;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - synchronous FIFO, push/full on the write side, valid/ready on the read side
module evt_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         pop;
  logic         wr_en;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_valid = (wr_ptr != rd_ptr);
  assign pop      = rd_valid && rd_ready;
  assign wr_en    = push && (!full || pop);
  // Empty FIFO presents code 0 so the output is defined straight out of reset.
  assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - button edge/long/repeat event generator with event FIFO; BTN_AUTO_REPEAT_EN enables REPEAT events
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int NBTN       = 5,
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NBTN-1:0]      btn_level,
  input  logic                 ovf_clr,
  output logic                 ovf,
  btn_event_ctrl_if.master     evt
);

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYC - 1);
  localparam logic [31:0] REP_LAST  = 32'(REPEAT_CYC - 1);

  logic [7:0]        lvl, prev, rise, fall;
  logic [7:0]        press_pend, rel_pend;
  logic [7:0]        press_sel, rel_sel, press_clr, rel_clr;
  logic              hold_pend, hold_sel, hold_clr;
  evt_type_e         hold_type;
  logic [IDX_W-1:0]  hold_idx;

  hold_state_e       state, state_nx;
  logic [31:0]       cnt, cnt_nx;
  logic [IDX_W-1:0]  trk, trk_nx;
  logic              fire;
  evt_type_e         fire_type;

  logic              sel_valid;
  logic [CODE_W-1:0] sel_code;
  logic              push, pop, full, lost;

  assign lvl  = 8'(btn_level);
  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;

  always_comb begin
    sel_valid = 1'b0;
    sel_code  = '0;
    hold_sel  = 1'b0;
    press_sel = '0;
    rel_sel   = '0;
    if (hold_pend) begin
      sel_valid = 1'b1;
      hold_sel  = 1'b1;
      sel_code  = {hold_type, hold_idx};
    end else if (|rel_pend) begin
      sel_valid = 1'b1;
      rel_sel   = 8'b1 << lowest_idx(rel_pend);
      sel_code  = {EVT_RELEASE, lowest_idx(rel_pend)};
    end else if (|press_pend) begin
      sel_valid = 1'b1;
      press_sel = 8'b1 << lowest_idx(press_pend);
      sel_code  = {EVT_PRESS, lowest_idx(press_pend)};
    end
  end

  assign pop       = evt.evt_valid && evt.evt_ready;
  assign push      = sel_valid && (!full || pop);
  assign press_clr = push ? press_sel : '0;
  assign rel_clr   = push ? rel_sel : '0;
  assign hold_clr  = push && hold_sel;

  // A pend bit that is being pushed this cycle is free to take a new edge without loss.
  assign lost = (|(rise & press_pend & ~press_clr)) ||
                (|(fall & rel_pend & ~rel_clr)) ||
                (fire && hold_pend && !hold_clr);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    trk_nx    = trk;
    fire      = 1'b0;
    fire_type = EVT_LONG;
    case (state)
      ST_IDLE: begin
        if (|lvl) begin
          trk_nx   = lowest_idx(lvl);
          cnt_nx   = '0;
          state_nx = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (!lvl[trk]) begin
          state_nx = ST_IDLE;
        end else if (cnt == HOLD_LAST) begin
          fire      = 1'b1;
          fire_type = EVT_LONG;
          cnt_nx    = '0;
`ifdef BTN_AUTO_REPEAT_EN
          state_nx  = ST_REPEAT;
`else
          state_nx  = ST_WAIT_REL;
`endif
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      ST_REPEAT: begin
        if (!lvl[trk]) begin
          state_nx = ST_IDLE;
        end else if (cnt == REP_LAST) begin
          fire      = 1'b1;
          fire_type = EVT_REPEAT;
          cnt_nx    = '0;
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      ST_WAIT_REL: begin
        if (!lvl[trk]) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      trk   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      trk   <= trk_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      press_pend <= '0;
      rel_pend   <= '0;
      hold_pend  <= 1'b0;
      hold_type  <= EVT_PRESS;
      hold_idx   <= '0;
      ovf        <= 1'b0;
    end else begin
      prev       <= lvl;
      press_pend <= (press_pend & ~press_clr) | rise;
      rel_pend   <= (rel_pend & ~rel_clr) | fall;
      if (fire && !(hold_pend && !hold_clr)) begin
        hold_pend <= 1'b1;
        hold_type <= fire_type;
        hold_idx  <= trk;
      end else if (hold_clr) begin
        hold_pend <= 1'b0;
      end
      if (ovf_clr)   ovf <= 1'b0;
      else if (lost) ovf <= 1'b1;
    end
  end

  evt_fifo #(
    .W     (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .wdata    (sel_code),
    .full     (full),
    .rd_valid (evt.evt_valid),
    .rd_ready (evt.evt_ready),
    .rd_data  (evt.evt_code)
  );

endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Event controller sitting between the board debouncer and the CPU-visible input register. Converts debounced button levels into press, release, long-press and auto-repeat events, arbitrates simultaneous events onto a single enqueue port, and buffers them in a small FIFO drained through a valid/ready handshake. Lost events are flagged by a sticky overflow bit.

## Interface
- NBTN, 5, number of buttons (1..8)
- HOLD_CYC, 50_000_000, cycles a tracked button must stay pressed before a LONG event
- REPEAT_CYC, 10_000_000, cycles between REPEAT events after LONG
- FIFO_DEPTH, 4, event FIFO entries (power of two, ≥2)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- btn_level  in  NBTN  debounced button levels, synchronous to clk, 1 = pressed
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head this cycle
- evt_code  out  5  {type[1:0], idx[2:0]}; type 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
- ovf  out  1  sticky: an event was lost
- ovf_clr  in  1  clears ovf

## Operation
- Edge detect: prev register per button; rising edge sets press_pend[i], falling edge sets release_pend[i]. Edge while same pend bit still set → ovf.
- Hold FSM, one shared counter (32 bit):
  - IDLE: if any btn_level set, track lowest set index, counter ← 0, go PRESSED.
  - PRESSED: counter++; tracked button released → IDLE; counter == HOLD_CYC-1 → set hold_pend (type LONG), counter ← 0, go REPEAT.
  - REPEAT: tracked released → IDLE; counter++; counter == REPEAT_CYC-1 → set hold_pend (type REPEAT), counter ← 0.
  - Other buttons pressed while tracking are ignored by the FSM (edges still reported).
- Arbiter: one push per cycle. Priority: hold_pend > release_pend (lowest idx) > press_pend (lowest idx). Selected pend bit cleared on push.
- FIFO: push when entry selected and (not full or pop same cycle). Full and no pop → pend bits stay set (retried, not dropped). hold_pend set while already set → ovf, new one dropped.
- Pop when evt_valid && evt_ready. evt_code = FIFO head; holds stable while valid and not ready.
- ovf_clr has priority over a same-cycle set (clear wins).

## Timing
- Reset: evt_valid 0, evt_code 0, ovf 0, prev 0, all pend 0, FSM IDLE, counter 0, FIFO empty.
- Button held through reset produces PRESS after reset release (prev resets to 0).
- btn_level change at edge N → pend set at N+1 → push at N+1 → evt_valid at N+2 (empty FIFO, no competing events).
- LONG enqueued HOLD_CYC+1 cycles after PRESSED entry; REPEAT every REPEAT_CYC cycles thereafter.
- Reset mid-operation discards FIFO and pending events; no partial events emitted.
- Simultaneous push+pop with FIFO full: both occur, occupancy unchanged.

## Configuration
- BTN_AUTO_REPEAT_EN defined: REPEAT state as above.
- Undefined: after LONG, FSM enters WAIT_REL (no counter, no events) until tracked release → IDLE; type 11 never produced.

## Structure
- Package btn_evt_pkg: event type constants (EVT_PRESS/RELEASE/LONG/REPEAT), FSM state enum, evt_code field widths.
- One sub-module: evt_fifo (parameterised sync FIFO, valid/ready read side, push/full write side).

## Test plan
- HOLD_CYC=16: press btn 2 for 5 cycles → PRESS 0x02 then RELEASE 0x0A, no LONG, ovf 0.
- Press btn 1 for 40 cycles, REPEAT_CYC=8, macro on → PRESS, LONG 0x11, then REPEAT 0x19 every 8 cycles, RELEASE 0x09; macro off → no 0x19.
- btn_level 0b00000→0b10101 in one cycle → PRESS 0x00, 0x02, 0x04 on consecutive pushes, in that order.
- evt_ready held 0, generate 6 edges, FIFO_DEPTH 4 → 4 events buffered, remaining pend retained, delivered in order once ready 1; ovf stays 0.
- Toggle btn 0 twice while FIFO full and ready 0 → ovf 1; ovf_clr pulse → ovf 0.
- Assert rst_n low with 3 queued events and FSM in REPEAT → evt_valid 0, ovf 0 immediately; after release no stale events.
